// File: rtl/sdpll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sdpll_ctrl_pkg
// Shared definitions for the sdpll acquisition/lock sequencer:
//   - STATE_W and the FSM state encodings (IDLE/LOAD/ACQ/GEAR/TRACK)
//   - win_w(): width of a window error count, which must hold 0..2^LGWINDOW
// No ports (package).
// -----------------------------------------------------------------------------
package sdpll_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ACQ   = 3'd2;
    localparam logic [STATE_W-1:0] ST_GEAR  = 3'd3;
    localparam logic [STATE_W-1:0] ST_TRACK = 3'd4;

    // One extra bit so a window in which every sample was an error
    // (count == 2^lgwindow) is representable.
    function automatic int win_w(input int lgwindow);
        return lgwindow + 1;
    endfunction

endpackage

// File: rtl/sdpll_err_window.sv
// -----------------------------------------------------------------------------
// sdpll_err_window
// Fixed-length observation window over the DPLL error stream.
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_clear    clears both counters (state change, or FSM parked in IDLE/LOAD)
//   i_ce       sample strobe; counters only advance on this
//   i_err      DPLL o_err; any non-zero code (including 2'b10) is an error
//   o_win_end  high on the i_ce cycle that completes a window
//   o_count    error count including the current sample; the final count of
//              the window when o_win_end is high
// -----------------------------------------------------------------------------
module sdpll_err_window
    import sdpll_ctrl_pkg::*;
#(
    parameter int LGWINDOW = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic                          i_ce,
    input  logic [1:0]                    i_err,
    output logic                          o_win_end,
    output logic [win_w(LGWINDOW)-1:0]    o_count
);

    localparam int WIN_W = win_w(LGWINDOW);
    localparam logic [WIN_W-1:0] ERR_MAX = {1'b1, {LGWINDOW{1'b0}}};

    logic [LGWINDOW-1:0] samp_cnt;
    logic [WIN_W-1:0]    err_cnt;
    logic [WIN_W-1:0]    err_inc;
    logic                is_err;

    assign is_err    = (i_err != 2'b00);
    assign o_win_end = i_ce && (samp_cnt == '1);

    // Count including this cycle's sample so the decision made on the
    // window-end edge sees the complete window.
    always_comb begin
        err_inc = err_cnt;
        if (i_ce && is_err && (err_cnt != ERR_MAX))
            err_inc = err_cnt + 1'b1;
    end

    assign o_count = err_inc;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            samp_cnt <= '0;
            err_cnt  <= '0;
        end else if (i_ce) begin
            // Sample counter wraps naturally from all-ones to zero.
            samp_cnt <= samp_cnt + 1'b1;
            err_cnt  <= o_win_end ? '0 : err_inc;
        end
    end

endmodule

// File: rtl/sdpll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// sdpll_lock_ctrl
// Acquisition and lock sequencer for the sdpll phase-tracking loop. Loads the
// phase step, starts the loop at a wide bandwidth, gear-shifts lgcoeff toward
// the narrow tracking value as error windows come back clean, and reports
// lock / loss of lock.
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_start      begin acquisition (IDLE only)
//   i_stop       abort to IDLE from any state
//   i_step       nominal phase step, captured on an accepted i_start
//   i_ce         sample strobe shared with the DPLL
//   i_err        DPLL o_err
//   o_ld         step-load pulse to the DPLL (high while in LOAD)
//   o_step       captured step value
//   o_lgcoeff    loop coefficient to the DPLL
//   o_locked     high in TRACK
//   o_loss       one-cycle pulse on loss of lock
//   o_busy       state != IDLE
//   o_state      current state encoding
//   o_err_count  error count of the last completed window
// -----------------------------------------------------------------------------
module sdpll_lock_ctrl
    import sdpll_ctrl_pkg::*;
#(
    parameter int         PHASE_BITS    = 16,
    parameter logic [4:0] LG_WIDE       = 5'd4,
    parameter logic [4:0] LG_NARROW     = 5'd10,
    parameter int         LGWINDOW      = 8,
    parameter int         LOCK_THRESH   = 4,
    parameter int         UNLOCK_THRESH = 32,
    parameter int         LOCK_WINDOWS  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic [PHASE_BITS-2:0]         i_step,
    input  logic                          i_ce,
    input  logic [1:0]                    i_err,
    output logic                          o_ld,
    output logic [PHASE_BITS-2:0]         o_step,
    output logic [4:0]                    o_lgcoeff,
    output logic                          o_locked,
    output logic                          o_loss,
    output logic                          o_busy,
    output logic [STATE_W-1:0]            o_state,
    output logic [win_w(LGWINDOW)-1:0]    o_err_count
);

    localparam int WIN_W  = win_w(LGWINDOW);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  LOCK_TH   = WIN_W'(LOCK_THRESH);
    localparam logic [WIN_W-1:0]  UNLOCK_TH = WIN_W'(UNLOCK_THRESH);
    localparam logic [GOOD_W-1:0] LOCK_WIN  = GOOD_W'(LOCK_WINDOWS);

    logic [STATE_W-1:0]  state, state_nxt;
    logic [GOOD_W-1:0]   good_cnt, good_nxt, good_inc;
    logic [4:0]          lg_nxt, lg_inc;
    logic                loss_nxt;
    logic [PHASE_BITS-2:0] step_nxt;
    logic [WIN_W-1:0]    errc_nxt;

    logic                win_end;
    logic                win_clear;
    logic [WIN_W-1:0]    win_count;
    logic                win_good;
    logic                win_bad;

    assign win_good = (win_count <= LOCK_TH);
    assign win_bad  = (win_count >  UNLOCK_TH);
    assign good_inc = good_cnt + 1'b1;
    assign lg_inc   = o_lgcoeff + 5'd1;

    // Counters restart on every state change and stay parked while no
    // window is meaningful (IDLE, LOAD).
    assign win_clear = (state_nxt != state) || (state == ST_IDLE) || (state == ST_LOAD);

    sdpll_err_window #(
        .LGWINDOW (LGWINDOW)
    ) u_win (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (win_clear),
        .i_ce      (i_ce),
        .i_err     (i_err),
        .o_win_end (win_end),
        .o_count   (win_count)
    );

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        lg_nxt    = o_lgcoeff;
        loss_nxt  = 1'b0;
        step_nxt  = o_step;
        errc_nxt  = o_err_count;

        case (state)
            ST_IDLE: begin
                lg_nxt   = LG_WIDE;
                good_nxt = '0;
                if (i_start) begin
                    step_nxt  = i_step;
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                lg_nxt    = LG_WIDE;
                good_nxt  = '0;
                state_nxt = ST_ACQ;
            end

            ST_ACQ: begin
                if (win_end) begin
                    errc_nxt = win_count;
                    if (win_good) begin
                        if (good_inc == LOCK_WIN) begin
                            good_nxt = '0;
                            // No gear range to walk when wide == narrow.
                            if (LG_WIDE == LG_NARROW) begin
                                lg_nxt    = LG_NARROW;
                                state_nxt = ST_TRACK;
                            end else begin
                                state_nxt = ST_GEAR;
                            end
                        end else begin
                            good_nxt = good_inc;
                        end
                    end else begin
                        good_nxt = '0;
                    end
                end
            end

            ST_GEAR: begin
                good_nxt = '0;
                if (win_end) begin
                    errc_nxt = win_count;
                    if (win_good) begin
                        lg_nxt = lg_inc;
                        if (lg_inc == LG_NARROW)
                            state_nxt = ST_TRACK;
                    end else if (win_bad) begin
                        // Fall back to wide bandwidth; the step already in
                        // the DPLL is kept.
                        lg_nxt    = LG_WIDE;
                        state_nxt = ST_ACQ;
                    end
                end
            end

            ST_TRACK: begin
                good_nxt = '0;
                lg_nxt   = LG_NARROW;
                if (win_end) begin
                    errc_nxt = win_count;
                    if (win_bad) begin
                        // Lock lost: restart through LOAD so the DPLL gets
                        // the captured step again.
                        loss_nxt  = 1'b1;
                        lg_nxt    = LG_WIDE;
                        state_nxt = ST_LOAD;
                    end
                end
            end

            default: begin
                lg_nxt    = LG_WIDE;
                good_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        // Stop overrides every other event, including a same-cycle start.
        if (i_stop) begin
            state_nxt = ST_IDLE;
            lg_nxt    = LG_WIDE;
            loss_nxt  = 1'b0;
            good_nxt  = '0;
            step_nxt  = o_step;
            errc_nxt  = o_err_count;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            o_lgcoeff   <= LG_WIDE;
            o_loss      <= 1'b0;
            o_step      <= '0;
            o_err_count <= '0;
        end else begin
            state       <= state_nxt;
            good_cnt    <= good_nxt;
            o_lgcoeff   <= lg_nxt;
            o_loss      <= loss_nxt;
            o_step      <= step_nxt;
            o_err_count <= errc_nxt;
        end
    end

    assign o_ld     = (state == ST_LOAD);
    assign o_locked = (state == ST_TRACK);
    assign o_busy   = (state != ST_IDLE);
    assign o_state  = state;

endmodule

// File: tb/tb_sdpll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdpll_lock_ctrl
// Directed scenarios for sdpll_lock_ctrl (LGWINDOW=4, LOCK_THRESH=4,
// UNLOCK_THRESH=8, LOCK_WINDOWS=4, LG_WIDE=4, LG_NARROW=10). The stimulus
// process queues the expected output events with their hand-computed cycle
// numbers; the monitor pops one expectation whenever the DUT shows an event
// (state/lgcoeff/err_count change, o_ld or o_loss high, or a snapshot request).
// -----------------------------------------------------------------------------
module tb_sdpll_lock_ctrl;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_stop, i_ce;
    logic [14:0] i_step;
    logic [1:0]  i_err;
    logic        o_ld, o_locked, o_loss, o_busy;
    logic [14:0] o_step;
    logic [4:0]  o_lgcoeff;
    logic [2:0]  o_state;
    logic [4:0]  o_err_count;

    always #5 clk = ~clk;

    sdpll_lock_ctrl #(
        .PHASE_BITS    (16),
        .LG_WIDE       (5'd4),
        .LG_NARROW     (5'd10),
        .LGWINDOW      (4),
        .LOCK_THRESH   (4),
        .UNLOCK_THRESH (8),
        .LOCK_WINDOWS  (4)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_step      (i_step),
        .i_ce        (i_ce),
        .i_err       (i_err),
        .o_ld        (o_ld),
        .o_step      (o_step),
        .o_lgcoeff   (o_lgcoeff),
        .o_locked    (o_locked),
        .o_loss      (o_loss),
        .o_busy      (o_busy),
        .o_state     (o_state),
        .o_err_count (o_err_count)
    );

    // Cycle stamp: number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // i_ce either always high, or 1 clock in 3 with errors only off-strobe.
    logic       ce_div = 1'b0;
    logic [1:0] err_drv = 2'b00;
    int         ph = 0;
    always @(posedge clk) ph <= (ph == 2) ? 0 : ph + 1;
    assign i_ce  = ce_div ? (ph == 0) : 1'b1;
    assign i_err = ce_div ? ((ph == 0) ? 2'b00 : 2'b01) : err_drv;

    typedef struct {
        string nm;
        int    c;
        int    st;
        int    lg;
        int    ld;
        int    loss;
        int    locked;
        int    step;
        int    errc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   snap_cnt = 0;
    int   snap_seen = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input string fld, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d (cycle %0d)", nm, fld, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input string nm, input int c, input int st, input int lg,
                             input int ld, input int loss, input int locked,
                             input int step, input int errc);
        exp_t e;
        e.nm = nm; e.c = c; e.st = st; e.lg = lg; e.ld = ld; e.loss = loss;
        e.locked = locked; e.step = step; e.errc = errc;
        q.push_back(e);
    endtask

    // Monitor / scoreboard
    logic [2:0] p_st;
    logic [4:0] p_lg;
    logic [4:0] p_errc;
    bit         primed = 1'b0;

    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (mon_en) begin
            ev = (snap_cnt != snap_seen);
            if (primed)
                ev = ev || (o_state != p_st) || (o_lgcoeff != p_lg) ||
                     (o_err_count != p_errc) || o_ld || o_loss;
            snap_seen = snap_cnt;
            p_st   = o_state;
            p_lg   = o_lgcoeff;
            p_errc = o_err_count;
            primed = 1'b1;
            if (ev) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: cycle %0d state %0d lg %0d ld %0b loss %0b errc %0d, expected no event",
                             cyc, o_state, o_lgcoeff, o_ld, o_loss, o_err_count);
                end else begin
                    e = q.pop_front();
                    chk(e.nm, "cycle",     cyc,              e.c);
                    chk(e.nm, "state",     int'(o_state),    e.st);
                    chk(e.nm, "busy",      int'(o_busy),     (e.st != 0) ? 1 : 0);
                    chk(e.nm, "lgcoeff",   int'(o_lgcoeff),  e.lg);
                    chk(e.nm, "ld",        int'(o_ld),       e.ld);
                    chk(e.nm, "loss",      int'(o_loss),     e.loss);
                    chk(e.nm, "locked",    int'(o_locked),   e.locked);
                    chk(e.nm, "step",      int'(o_step),     e.step);
                    chk(e.nm, "err_count", int'(o_err_count), e.errc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) tick(1);
    endtask

    // n error samples on consecutive strobes, cycling through 01, 10, 11.
    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            err_drv = 2'((i % 3) + 1);
            tick(1);
        end
        err_drv = 2'b00;
    endtask

    int c0, c1;

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_stop  = 1'b0;
        i_step  = '0;

        // Reset state
        tick(3);
        i_reset = 1'b0;
        mon_en  = 1'b1;
        expect_ev("reset", cyc, 0, 4, 0, 0, 0, 0, 0);
        snap_cnt++;
        tick(2);

        // Start, acquisition with clean error stream, gear shift, track
        c0 = cyc;
        expect_ev("load",  c0 + 1,  1, 4, 1, 0, 0, 'h123, 0);
        expect_ev("acq",   c0 + 2,  2, 4, 0, 0, 0, 'h123, 0);
        expect_ev("gear",  c0 + 66, 3, 4, 0, 0, 0, 'h123, 0);
        for (int k = 1; k <= 5; k++)
            expect_ev("gear_step", c0 + 66 + 16 * k, 3, 4 + k, 0, 0, 0, 'h123, 0);
        expect_ev("track", c0 + 162, 4, 10, 0, 0, 1, 'h123, 0);
        i_step  = 15'h0123;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        i_step  = 15'h0000;
        wait_to(c0 + 162);

        // Loss of lock in TRACK, reload, reacquire with a 4-error (good) window
        expect_ev("loss",      c0 + 178, 1, 4, 1, 1, 0, 'h123, 9);
        expect_ev("reacq",     c0 + 179, 2, 4, 0, 0, 0, 'h123, 9);
        expect_ev("acq_err4",  c0 + 195, 2, 4, 0, 0, 0, 'h123, 4);
        expect_ev("acq_clean", c0 + 211, 2, 4, 0, 0, 0, 'h123, 0);
        expect_ev("gear2",     c0 + 243, 3, 4, 0, 0, 0, 'h123, 0);
        expect_ev("gear2_lg5", c0 + 259, 3, 5, 0, 0, 0, 'h123, 0);
        expect_ev("gear2_lg6", c0 + 275, 3, 6, 0, 0, 0, 'h123, 0);
        expect_ev("gear2_lg7", c0 + 291, 3, 7, 0, 0, 0, 'h123, 0);
        burst(9);
        wait_to(c0 + 179);
        burst(4);

        // GEAR at lgcoeff 7: 6 and 8 errors hold, 9 errors fall back to ACQ
        expect_ev("hold6",      c0 + 307, 3, 7, 0, 0, 0, 'h123, 6);
        expect_ev("hold8",      c0 + 323, 3, 7, 0, 0, 0, 'h123, 8);
        expect_ev("bad9",       c0 + 339, 2, 4, 0, 0, 0, 'h123, 9);
        expect_ev("acq3_clean", c0 + 355, 2, 4, 0, 0, 0, 'h123, 0);
        expect_ev("gear3",      c0 + 403, 3, 4, 0, 0, 0, 'h123, 0);
        expect_ev("gear3_lg5",  c0 + 419, 3, 5, 0, 0, 0, 'h123, 0);
        expect_ev("gear3_lg6",  c0 + 435, 3, 6, 0, 0, 0, 'h123, 0);
        wait_to(c0 + 291);
        burst(6);
        wait_to(c0 + 307);
        burst(8);
        wait_to(c0 + 323);
        burst(9);

        // Stop mid-GEAR, then start+stop together in IDLE
        expect_ev("stop",      c0 + 442, 0, 4, 0, 0, 0, 'h123, 0);
        expect_ev("idle_hold", c0 + 445, 0, 4, 0, 0, 0, 'h123, 0);
        wait_to(c0 + 441);
        i_stop = 1'b1;
        tick(1);
        i_start = 1'b1;
        i_step  = 15'h0456;
        tick(1);
        i_start = 1'b0;
        i_stop  = 1'b0;
        wait_to(c0 + 445);
        snap_cnt++;
        tick(2);

        // i_ce one clock in three, errors only on non-strobe cycles
        ce_div = 1'b1;
        while (ph != 1) tick(1);
        c1 = cyc;
        expect_ev("ce3_load", c1 + 1,   1, 4, 1, 0, 0, 'hABC, 0);
        expect_ev("ce3_acq",  c1 + 2,   2, 4, 0, 0, 0, 'hABC, 0);
        expect_ev("ce3_gear", c1 + 192, 3, 4, 0, 0, 0, 'hABC, 0);
        for (int k = 1; k <= 5; k++)
            expect_ev("ce3_step", c1 + 192 + 48 * k, 3, 4 + k, 0, 0, 0, 'hABC, 0);
        expect_ev("ce3_track", c1 + 480, 4, 10, 0, 0, 1, 'hABC, 0);
        i_step  = 15'h0ABC;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_to(c1 + 500);

        // Every queued expectation must have been matched by a DUT event
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected events never seen, first '%s' at cycle %0d",
                     q.size(), q[0].nm, q[0].c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
